// File: rtl/cpu_pkg.sv
// Shared types and instruction encodings for the 9-bit accumulator CPU front end.
package cpu_pkg;
  localparam int INST_W = 9;
  localparam logic [INST_W-1:0] ACK_INST = 9'h1FF;
  localparam logic [2:0] OP_B = 3'd3;
  localparam logic [3:0] OP_BTRU = 4'd11;

  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/branch_lut.sv
// Branch-target register file: async reset, one synchronous write port, one combinational read port.
module branch_lut #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [3:0]      waddr,
  input  logic [PC_W-1:0] wdata,
  input  logic [3:0]      raddr,
  output logic [PC_W-1:0] rdata
);
  logic [PC_W-1:0] mem [LUT_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LUT_DEPTH; i++) mem[i] <= '0;
    end else if (we && (int'(waddr) < LUT_DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Indices beyond the populated depth read as zero.
  always_comb begin
    rdata = '0;
    if (int'(raddr) < LUT_DEPTH) rdata = mem[raddr];
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: owns the PC, resolves B/BTRU through the branch LUT, runs Start/Done.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int LUT_DEPTH  = 16,
  parameter int START_ADDR = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic [PC_W-1:0]   InstAddr,
  input  logic [INST_W-1:0] InstData,
  output logic [INST_W-1:0] Instruction,
  input  logic              Taken,
  input  logic              LutWe,
  input  logic [3:0]        LutAddr,
  input  logic [PC_W-1:0]   LutData,
  output logic              Done,
  output logic [15:0]       CycleCount
);
  fetch_state_t    state_p0, state_n;
  logic [PC_W-1:0] pc_p0, pc_n;
  logic [15:0]     cnt_p0, cnt_n;
  logic            done_p0, done_n;
  logic            is_b, is_btru;
  logic            lut_we;
  logic [3:0]      lut_raddr;
  logic [PC_W-1:0] lut_rdata;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Bit 7 plays no part in branch decode.
  assign is_b      = InstData[8] && (InstData[6:4] == OP_B);
  assign is_btru   = !InstData[8] && (InstData[6:3] == OP_BTRU);
  assign lut_raddr = InstData[8] ? InstData[3:0] : {1'b0, InstData[2:0]};
  assign lut_we    = LutWe && (state_p0 != RUN);

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_DEPTH (LUT_DEPTH)
  ) u_lut (
    .clk   (Clk),
    .rst   (Reset),
    .we    (lut_we),
    .waddr (LutAddr),
    .wdata (LutData),
    .raddr (lut_raddr),
    .rdata (lut_rdata)
  );

  always_comb begin
    state_n = state_p0;
    pc_n    = pc_p0;
    cnt_n   = cnt_p0;
    done_n  = done_p0;
    unique case (state_p0)
      IDLE: begin
        if (Start) begin
          state_n = RUN;
          pc_n    = PC_W'(START_ADDR);
          cnt_n   = '0;
        end
      end
      RUN: begin
        cnt_n = sat_inc(cnt_p0);
        if (InstData == ACK_INST) begin
          state_n = HALT;
          done_n  = 1'b1;
        end else if (is_b || (is_btru && Taken)) begin
          pc_n = lut_rdata;
        end else begin
          pc_n = pc_p0 + 1'b1;
        end
      end
      HALT: begin
        if (Start) begin
          state_n = RUN;
          done_n  = 1'b0;
          pc_n    = PC_W'(START_ADDR);
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_p0 <= IDLE;
      pc_p0    <= PC_W'(START_ADDR);
      cnt_p0   <= '0;
      done_p0  <= 1'b0;
    end else begin
      state_p0 <= state_n;
      pc_p0    <= pc_n;
      cnt_p0   <= cnt_n;
      done_p0  <= done_n;
    end
  end

  assign InstAddr    = pc_p0;
  assign Instruction = (state_p0 == RUN) ? InstData : '0;
  assign Done        = done_p0;
  assign CycleCount  = cnt_p0;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural instruction memory.
module tb_fetch_sequencer;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [9:0]  InstAddr;
  logic [8:0]  InstData;
  logic [8:0]  Instruction;
  logic        Taken = 1'b0;
  logic        LutWe = 1'b0;
  logic [3:0]  LutAddr = 4'd0;
  logic [9:0]  LutData = 10'd0;
  logic        Done;
  logic [15:0] CycleCount;

  logic [8:0] mem [1024];
  int checks = 0;
  int errors = 0;

  localparam logic [8:0] ADD = 9'h010;
  localparam logic [8:0] ACK = 9'h1FF;

  assign InstData = mem[InstAddr];

  fetch_sequencer #(.PC_W(10), .LUT_DEPTH(16), .START_ADDR(0)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .InstAddr    (InstAddr),
    .InstData    (InstData),
    .Instruction (Instruction),
    .Taken       (Taken),
    .LutWe       (LutWe),
    .LutAddr     (LutAddr),
    .LutData     (LutData),
    .Done        (Done),
    .CycleCount  (CycleCount)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = ADD;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic do_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic lut_write(input logic [3:0] a, input logic [9:0] d);
    LutWe = 1'b1; LutAddr = a; LutData = d;
    tick();
    LutWe = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    do_reset();
    checks++; if (InstAddr !== 10'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", InstAddr); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
    checks++; if (CycleCount !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", CycleCount); end
    checks++; if (Instruction !== 9'h000) begin errors++; $display("FAIL reset_inst: got %h want 000", Instruction); end
    lut_write(4'd3, 10'd50);
    do_start();
    repeat (5) tick();
    checks++; if (InstAddr !== 10'd5 || CycleCount !== 16'd5) begin errors++; $display("FAIL run_to_5: addr %0d cnt %0d want 5 5", InstAddr, CycleCount); end
    Reset = 1'b1;
    #1;
    checks++; if (InstAddr !== 10'd0 || Done !== 1'b0 || CycleCount !== 16'd0 || Instruction !== 9'h000) begin
      errors++; $display("FAIL midrun_reset: addr %0d done %b cnt %0d inst %h want 0 0 0 000", InstAddr, Done, CycleCount, Instruction);
    end
    tick();
    Reset = 1'b0;
    tick();
    tick();
    checks++; if (InstAddr !== 10'd0 || CycleCount !== 16'd0 || Instruction !== 9'h000) begin
      errors++; $display("FAIL idle_after_reset: addr %0d cnt %0d inst %h want 0 0 000", InstAddr, CycleCount, Instruction);
    end
    mem[0] = ADD; mem[1] = 9'h133; mem[2] = ACK;
    do_start();
    tick();
    checks++; if (Instruction !== 9'h133) begin errors++; $display("FAIL inst_passthru: got %h want 133", Instruction); end
    tick();
    checks++; if (InstAddr !== 10'd0) begin errors++; $display("FAIL lut_cleared: got %0d want 0", InstAddr); end
  endtask

  task automatic test_branch_b();
    clear_mem();
    do_reset();
    lut_write(4'd2, 10'd40);
    mem[1] = 9'h132; mem[40] = ACK;
    do_start();
    checks++; if (InstAddr !== 10'd0) begin errors++; $display("FAIL b_seq0: got %0d want 0", InstAddr); end
    tick();
    checks++; if (InstAddr !== 10'd1) begin errors++; $display("FAIL b_seq1: got %0d want 1", InstAddr); end
    tick();
    checks++; if (InstAddr !== 10'd40 || Done !== 1'b0) begin errors++; $display("FAIL b_seq40: addr %0d done %b want 40 0", InstAddr, Done); end
    tick();
    checks++; if (Done !== 1'b1 || CycleCount !== 16'd3 || InstAddr !== 10'd40 || Instruction !== 9'h000) begin
      errors++; $display("FAIL b_halt: done %b cnt %0d addr %0d inst %h want 1 3 40 000", Done, CycleCount, InstAddr, Instruction);
    end
    repeat (3) tick();
    checks++; if (Done !== 1'b1 || CycleCount !== 16'd3) begin errors++; $display("FAIL halt_hold: done %b cnt %0d want 1 3", Done, CycleCount); end
  endtask

  task automatic test_btru();
    clear_mem();
    do_reset();
    lut_write(4'd2, 10'd100);
    mem[4] = 9'h05A; mem[5] = ACK; mem[100] = 9'h0DA; mem[101] = ACK;
    Taken = 1'b0;
    do_start();
    repeat (4) tick();
    checks++; if (InstAddr !== 10'd4) begin errors++; $display("FAIL btru_at4: got %0d want 4", InstAddr); end
    tick();
    checks++; if (InstAddr !== 10'd5) begin errors++; $display("FAIL btru_not_taken: got %0d want 5", InstAddr); end
    tick();
    Taken = 1'b1;
    do_start();
    repeat (4) tick();
    tick();
    checks++; if (InstAddr !== 10'd100) begin errors++; $display("FAIL btru_taken: got %0d want 100", InstAddr); end
    tick();
    checks++; if (InstAddr !== 10'd100) begin errors++; $display("FAIL btru_bit7_ignored: got %0d want 100", InstAddr); end
    Taken = 1'b0;
    tick();
    checks++; if (InstAddr !== 10'd101) begin errors++; $display("FAIL btru_fallthru: got %0d want 101", InstAddr); end
    tick();
    checks++; if (Done !== 1'b1 || CycleCount !== 16'd8) begin errors++; $display("FAIL btru_halt: done %b cnt %0d want 1 8", Done, CycleCount); end
  endtask

  task automatic test_restart();
    clear_mem();
    do_reset();
    mem[3] = ACK;
    do_start();
    repeat (4) tick();
    checks++; if (Done !== 1'b1 || CycleCount !== 16'd4) begin errors++; $display("FAIL rs_halt: done %b cnt %0d want 1 4", Done, CycleCount); end
    do_start();
    checks++; if (Done !== 1'b0 || InstAddr !== 10'd0 || CycleCount !== 16'd0) begin
      errors++; $display("FAIL rs_restart: done %b addr %0d cnt %0d want 0 0 0", Done, InstAddr, CycleCount);
    end
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checks++; if (InstAddr !== 10'd2 || CycleCount !== 16'd2) begin errors++; $display("FAIL start_in_run: addr %0d cnt %0d want 2 2", InstAddr, CycleCount); end
    tick();
    tick();
    checks++; if (Done !== 1'b1 || CycleCount !== 16'd4) begin errors++; $display("FAIL rs_halt2: done %b cnt %0d want 1 4", Done, CycleCount); end
  endtask

  task automatic test_lut_write_run();
    clear_mem();
    do_reset();
    lut_write(4'd1, 10'd20);
    mem[2] = 9'h131; mem[20] = ACK; mem[77] = ACK;
    do_start();
    LutWe = 1'b1; LutAddr = 4'd1; LutData = 10'd77;
    tick();
    tick();
    LutWe = 1'b0;
    checks++; if (InstAddr !== 10'd2) begin errors++; $display("FAIL lw_at2: got %0d want 2", InstAddr); end
    tick();
    checks++; if (InstAddr !== 10'd20) begin errors++; $display("FAIL lw_run_ignored: got %0d want 20", InstAddr); end
    tick();
    LutWe = 1'b1; LutAddr = 4'd1; LutData = 10'd77; Start = 1'b1;
    tick();
    LutWe = 1'b0; Start = 1'b0;
    checks++; if (InstAddr !== 10'd0 || Done !== 1'b0) begin errors++; $display("FAIL lw_restart: addr %0d done %b want 0 0", InstAddr, Done); end
    tick();
    tick();
    tick();
    checks++; if (InstAddr !== 10'd77) begin errors++; $display("FAIL lw_halt_write: got %0d want 77", InstAddr); end
  endtask

  task automatic test_wrap_sat();
    clear_mem();
    do_reset();
    do_start();
    repeat (1023) tick();
    checks++; if (InstAddr !== 10'd1023) begin errors++; $display("FAIL pc_max: got %0d want 1023", InstAddr); end
    tick();
    checks++; if (InstAddr !== 10'd0 || CycleCount !== 16'd1024) begin errors++; $display("FAIL pc_wrap: addr %0d cnt %0d want 0 1024", InstAddr, CycleCount); end
    repeat (70000 - 1024) tick();
    checks++; if (CycleCount !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat: got %h want ffff", CycleCount); end
    tick();
    checks++; if (CycleCount !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat_hold: got %h want ffff", CycleCount); end
  endtask

  initial begin
    test_reset();
    test_branch_b();
    test_btru();
    test_restart();
    test_lut_write_run();
    test_wrap_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
